// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Bridges a single-outstanding request/response bus onto an APB master port.
// One PSEL is driven; an external decoder fans it out by PADDR. A wait-state
// counter aborts transfers to hung or unmapped slaves after TIMEOUT_CYCLES.
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    // request / response side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // APB master side
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter value seen in the last permitted wait cycle.
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] WAIT_LAST  =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t          state, state_d;
    logic [TO_W-1:0] wait_cnt, wait_cnt_d;

    logic [31:0] paddr_d, pwdata_d, rsp_rdata_d;
    logic [3:0]  pstrb_d;
    logic        pwrite_d, psel_d, penable_d, rsp_valid_d, rsp_err_d;
    logic        timeout_hit;

    // Requests are only taken in IDLE; gating with rst keeps every output low
    // while reset is held.
    assign req_ready   = (state == IDLE) && !rst;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

    // Next-state and next-output logic for the APB sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        paddr_d     = PADDR;
        pwrite_d    = PWRITE;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        unique case (state)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_valid) begin
                    paddr_d    = {req_addr[31:2], 2'b00};
                    pwrite_d   = req_write;
                    pwdata_d   = req_wdata;
                    pstrb_d    = req_write ? req_strb : 4'b0000;
                    psel_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a coincident timeout.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!PWRITE && !PSLVERR) ? PRDATA : 32'h0;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PADDR     <= 32'h0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'h0;
            PSTRB     <= 4'h0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            PADDR     <= paddr_d;
            PWRITE    <= pwrite_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed plus randomized transfers against a transaction-level model of the
// bridge: expected response and ACCESS-cycle count derive from wait states.
module tb_apb_master_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    apb_master_bridge #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ":PSEL"},      32'(PSEL),      32'h0);
        check({name, ":PENABLE"},   32'(PENABLE),   32'h0);
        check({name, ":PADDR"},     PADDR,          32'h0);
        check({name, ":PWRITE"},    32'(PWRITE),    32'h0);
        check({name, ":PWDATA"},    PWDATA,         32'h0);
        check({name, ":PSTRB"},     32'(PSTRB),     32'h0);
        check({name, ":rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({name, ":rsp_rdata"}, rsp_rdata,      32'h0);
        check({name, ":rsp_err"},   32'(rsp_err),   32'h0);
        check({name, ":req_ready"}, 32'(req_ready), 32'h0);
    endtask

    // One transfer; the slave holds PREADY low for 'waits' ACCESS cycles.
    task automatic do_xfer(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int waits, input logic [31:0] prdata, input logic slverr);
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
        logic        exp_err, completes, got, hold_ok;
        int          exp_acc, n_acc, lat;
        logic [31:0] held_rdata;

        // Reference: completion happens only if the slave is ready within TO cycles.
        completes = (waits < TO);
        exp_acc   = completes ? waits + 1 : TO;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_strb  = wr ? strb : 4'h0;
        exp_err   = completes ? slverr : 1'b1;
        exp_rdata = (completes && !wr && !slverr) ? prdata : 32'h0;

        @(negedge clk);
        check({name, ":idle_ready"}, 32'(req_ready), 32'h1);
        check({name, ":idle_psel"},  32'(PSEL),      32'h0);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_strb = strb;

        @(negedge clk);                       // SETUP cycle
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom; req_strb = 4'($urandom);
        check({name, ":setup_psel"},    32'(PSEL),      32'h1);
        check({name, ":setup_penable"}, 32'(PENABLE),   32'h0);
        check({name, ":setup_ready"},   32'(req_ready), 32'h0);
        check({name, ":PADDR"},         PADDR,          exp_addr);
        check({name, ":PWRITE"},        32'(PWRITE),    32'(wr));
        check({name, ":PWDATA"},        PWDATA,         wdata);
        check({name, ":PSTRB"},         32'(PSTRB),     32'(exp_strb));

        n_acc = 0; got = 1'b0; hold_ok = 1'b1; lat = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
            end else if (PSEL && PENABLE) begin
                hold_ok = hold_ok && (PADDR === exp_addr) && (PWRITE === wr) &&
                          (PWDATA === wdata) && (PSTRB === exp_strb) && !req_ready;
                PREADY  = (n_acc == waits);
                PRDATA  = prdata;
                PSLVERR = slverr;
                n_acc++;
            end else begin
                hold_ok = 1'b0;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

        check({name, ":rsp_seen"},    32'(got),       32'h1);
        check({name, ":access_cnt"},  32'(n_acc),     32'(exp_acc));
        check({name, ":latency"},     32'(lat),       32'(exp_acc + 1));
        check({name, ":hold_stable"}, 32'(hold_ok),   32'h1);
        check({name, ":rsp_err"},     32'(rsp_err),   32'(exp_err));
        check({name, ":rsp_rdata"},   rsp_rdata,      exp_rdata);
        check({name, ":end_psel"},    32'(PSEL),      32'h0);
        check({name, ":end_penable"}, 32'(PENABLE),   32'h0);
        check({name, ":end_ready"},   32'(req_ready), 32'h1);
        held_rdata = rsp_rdata;

        @(negedge clk);
        check({name, ":rsp_pulse"}, 32'(rsp_valid), 32'h0);
        check({name, ":rsp_hold"},  rsp_rdata,      held_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed cases
        do_xfer("wr0",     1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 4'hF, 0, 32'h5555_5555, 1'b0);
        do_xfer("rd3",     1'b0, 32'h0001_0010, 32'hA5A5_0000, 4'hF, 3, 32'h1234_5678, 1'b0);

        // Reset in ACCESS: outputs cleared, no response
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4444;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid:in_access", 32'(PSEL && PENABLE), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid:no_rsp", 32'(rsp_valid), 32'h0);
        check("rst_mid:ready",  32'(req_ready), 32'h1);
        check("rst_mid:psel",   32'(PSEL),      32'h0);

        do_xfer("slverr",  1'b0, 32'h0000_0100, 32'h0,         4'h3, 1, 32'hFFFF_FFFF, 1'b1);
        do_xfer("timeout", 1'b0, 32'h0000_3000, 32'h0,         4'h0, 10, 32'h1111_2222, 1'b0);
        do_xfer("to_edge", 1'b0, 32'h0000_3004, 32'h0,         4'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
        do_xfer("to_wr",   1'b1, 32'h0000_3008, 32'h7777_8888, 4'h5, TO, 32'h0, 1'b0);

        // Back-to-back writes with req_valid held high
        begin
            logic [31:0] b_addr [2];
            int          rise [2];
            logic [31:0] rise_addr [2];
            int          nr, acc, nrsp;
            logic        prev;
            b_addr[0] = 32'h0000_1004; b_addr[1] = 32'h0000_2008;
            rise[0] = 0; rise[1] = 0; rise_addr[0] = '0; rise_addr[1] = '0;
            nr = 0; acc = 0; nrsp = 0; prev = 1'b0;
            PREADY = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (PSEL && !prev && nr < 2) begin
                    rise[nr] = c; rise_addr[nr] = PADDR; nr++;
                end
                prev = PSEL;
                if (rsp_valid) nrsp++;
                req_valid = (acc < 2);
                if (acc < 2) begin
                    req_write = 1'b1; req_addr = b_addr[acc];
                    req_wdata = 32'h0BAD_0000 + 32'(acc); req_strb = 4'hF;
                    if (req_ready) acc++;
                end
            end
            req_valid = 1'b0; PREADY = 1'b0;
            check("b2b:rises",   32'(nr),                32'h2);
            check("b2b:period",  32'(rise[1] - rise[0]), 32'h3);
            check("b2b:addr0",   rise_addr[0],           32'h0000_1004);
            check("b2b:addr1",   rise_addr[1],           32'h0000_2008);
            check("b2b:rsp_cnt", 32'(nrsp),              32'h2);
        end

        // Randomized transfers
        for (int i = 0; i < 16; i++) begin
            do_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 6)), $urandom,
                    ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple single-outstanding request/response bus into APB transfers for the peripheral subsystem.
- Drives one PSEL plus the shared PADDR, PWRITE, PWDATA, PSTRB and PENABLE signals.
- The external APB address decoder fans PSEL out to PSELx0..PSELx8 from PADDR. The slave-side PRDATA/PREADY/PSLVERR multiplexer sits outside this block.
- Adds a bounded wait-state timeout so that a hung or unmapped slave cannot stall the core.

Parameters:
- TIMEOUT_CYCLES, 255: number of ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.
- TO_W, 16: width of the wait counter; TIMEOUT_CYCLES must be < 2^TO_W.

Ports:
- clk  in  1  system/APB clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_strb  in  4  write byte lanes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and on error.
- rsp_err  out  1  slave error or timeout; valid with rsp_valid.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB write strobes.
- PSEL  out  1  APB select, fed to the decoder.
- PENABLE  out  1  APB access phase.
- PRDATA  in  32  muxed slave read data.
- PREADY  in  1  muxed slave ready.
- PSLVERR  in  1  muxed slave error.

Behaviour:
- Reset: every output is 0; state is IDLE; the wait counter is 0.
- Reset during any state aborts the transfer immediately:
  - No rsp_valid is emitted.
  - PSEL and PENABLE are 0 in the cycle after rst is sampled.
- States: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - req_ready = 1.
  - On req_valid:
    - capture PADDR = {req_addr[31:2],2'b00}, PWRITE = req_write, PWDATA = req_wdata.
    - capture PSTRB = req_write ? req_strb : 4'b0000.
    - set PSEL = 1 and go to SETUP.
  - Without req_valid: PSEL = PENABLE = 0.
- SETUP: req_ready = 0; lasts exactly one cycle; then PENABLE = 1 and go to ACCESS.
- ACCESS: req_ready = 0; PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY = 1 (completion):
    - next cycle: PSEL = PENABLE = 0 and state returns to IDLE.
    - rsp_valid = 1 and rsp_err = PSLVERR.
    - rsp_rdata = (!PWRITE && !PSLVERR) ? PRDATA : 0.
  - PREADY = 0: the wait counter increments.
    - Abort when TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with PREADY still low.
    - Abort response, same timing as completion: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY = 1 in the same cycle as the timeout threshold: PREADY wins, and the normal completion response is returned.
- The wait counter clears on entry to SETUP.
- Latency: request accepted at edge N; SETUP is cycle N+1; ACCESS is cycle N+2. With zero wait states, rsp_valid is high in cycle N+3.
- Back-to-back: in the cycle rsp_valid is high, state is IDLE and req_ready = 1. A new request is accepted there, which gives a 3-cycle minimum transfer period.
- PSEL is never high for two transfers without passing through IDLE. PENABLE is never high without PSEL.
- rsp_valid is high for exactly one cycle per accepted request, except after reset.
- Response outputs hold their last value when rsp_valid = 0; rsp_valid itself returns to 0.

Test Plan:
- Write, 0 waits:
  - Stimulus: req addr 0x0000_0203, wdata 0xDEADBEEF, strb 0xF.
  - Response: PADDR = 0x0000_0200; PSEL rises at N+1; PENABLE is high at N+2 only; rsp_valid at N+3 with rsp_err = 0 and rsp_rdata = 0.
- Read, 3 waits:
  - Stimulus: addr 0x0001_0010; PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x12345678.
  - Response: rsp_rdata = 0x12345678; PADDR, PWRITE and PSTRB (0) held stable throughout; PSTRB = 0.
- Slave error:
  - Stimulus: read completing with PSLVERR = 1 and PRDATA = 0xFFFF_FFFF.
  - Response: rsp_err = 1, rsp_rdata = 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, PREADY held low.
  - Response: exactly 4 ACCESS cycles; rsp_valid with rsp_err = 1; PSEL = 0 afterwards.
  - Repeat with PREADY rising on the 4th cycle: normal completion, no error.
- Back-to-back and reset:
  - Stimulus: req_valid held high with two writes.
  - Response: second transfer's PSEL rises 3 cycles after the first's.
  - Stimulus: assert rst during ACCESS.
  - Response: next cycle all outputs 0 and no rsp_valid.
